// File: rtl/boost_pwm_ctrl_if.sv
// Boost PWM controller bus.
// Groups the command side (enable, duty load, fault handling) and the
// observation side (switch command, carrier, applied duty, state) of the
// boost PWM controller.
//   master : control/MPC layer; drives en, duty_cmd, duty_ld, fault_in,
//            fault_clr and observes the controller outputs.
//   slave  : boost_pwm_ctrl; consumes commands and drives sp, cnt,
//            period_start, duty_act, state and fault.
interface boost_pwm_ctrl_if #(
  parameter int CNT_W = 10
);
  logic             en;
  logic [CNT_W-1:0] duty_cmd;
  logic             duty_ld;
  logic             fault_in;
  logic             fault_clr;
  logic             sp;
  logic [CNT_W-1:0] cnt;
  logic             period_start;
  logic [CNT_W-1:0] duty_act;
  logic [1:0]       state;
  logic             fault;

  modport master (
    output en, duty_cmd, duty_ld, fault_in, fault_clr,
    input  sp, cnt, period_start, duty_act, state, fault
  );

  modport slave (
    input  en, duty_cmd, duty_ld, fault_in, fault_clr,
    output sp, cnt, period_start, duty_act, state, fault
  );
endinterface

// File: rtl/boost_pwm_ctrl.sv
// Boost-stage PWM controller.
// Generates the switching command sp for the downstream dead-time block from
// a free-running carrier, a double-buffered clamped duty, a per-period
// soft-start ramp and a latched fault shutdown.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : boost_pwm_ctrl_if slave (commands in, sp/cnt/period_start/
//          duty_act/state/fault out, all registered)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | converter off, carrier held at 0, sp low
// SOFTSTART | carrier running, duty_act ramps by SS_STEP per period
// RUN       | carrier running, duty_act follows shadow every period
// FAULT     | latched shutdown, waits for fault_clr with fault_in low
module boost_pwm_ctrl #(
  parameter int CNT_W    = 10,
  parameter int PERIOD   = 1000,
  parameter int DUTY_MAX = 900,
  parameter int SS_STEP  = 1
) (
  input  logic            clk,
  input  logic            rst,
  boost_pwm_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SOFTSTART = 2'd1,
    RUN       = 2'd2,
    FAULT     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] DMAX     = CNT_W'(DUTY_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W:0]   STEP     = (CNT_W + 1)'(SS_STEP);

  state_t           st;
  state_t           st_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] duty_nxt;
  logic [CNT_W-1:0] duty_sh;
  logic [CNT_W-1:0] duty_ld_val;
  logic [CNT_W:0]   ramp;
  logic             wrap;
  logic             active_nxt;

  assign duty_ld_val = (bus.duty_cmd > DMAX) ? DMAX : bus.duty_cmd;
  // One bit wider than the duty so a large step can never wrap past the target.
  assign ramp        = {1'b0, bus.duty_act} + STEP;
  assign wrap        = ((st == SOFTSTART) || (st == RUN)) && (bus.cnt == CNT_LAST);

  always_comb begin
    st_nxt   = st;
    cnt_nxt  = bus.cnt;
    duty_nxt = bus.duty_act;
    if (bus.fault_in) begin
      st_nxt   = FAULT;
      cnt_nxt  = '0;
      duty_nxt = '0;
    end else begin
      case (st)
        IDLE: begin
          cnt_nxt  = '0;
          duty_nxt = '0;
          if (bus.en) st_nxt = SOFTSTART;
        end
        SOFTSTART, RUN: begin
          if (!bus.en) begin
            st_nxt   = IDLE;
            cnt_nxt  = '0;
            duty_nxt = '0;
          end else if (wrap) begin
            cnt_nxt = '0;
            // Boundary uses the shadow value held before this edge.
            if (st == RUN) begin
              duty_nxt = duty_sh;
            end else if (ramp >= {1'b0, duty_sh}) begin
              duty_nxt = duty_sh;
              st_nxt   = RUN;
            end else begin
              duty_nxt = ramp[CNT_W-1:0];
            end
          end else begin
            cnt_nxt = bus.cnt + CNT_ONE;
          end
        end
        FAULT: begin
          cnt_nxt  = '0;
          duty_nxt = '0;
          if (bus.fault_clr) st_nxt = IDLE;
        end
        default: begin
          st_nxt   = IDLE;
          cnt_nxt  = '0;
          duty_nxt = '0;
        end
      endcase
    end
  end

  assign active_nxt = (st_nxt == SOFTSTART) || (st_nxt == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      st               <= IDLE;
      bus.cnt          <= '0;
      bus.duty_act     <= '0;
      bus.sp           <= 1'b0;
      bus.period_start <= 1'b0;
      bus.fault        <= 1'b0;
      duty_sh          <= '0;
    end else begin
      st               <= st_nxt;
      bus.cnt          <= cnt_nxt;
      bus.duty_act     <= duty_nxt;
      // sp is derived from next-cycle values so it stays registered yet
      // matches cnt < duty_act in the same cycle.
      bus.sp           <= active_nxt && (cnt_nxt < duty_nxt);
      bus.period_start <= active_nxt && (cnt_nxt == '0);
      bus.fault        <= (st_nxt == FAULT);
      if (bus.duty_ld) duty_sh <= duty_ld_val;
    end
  end

  assign bus.state = st;

endmodule

// File: tb/tb_boost_pwm_ctrl.sv
// Self-checking bench for boost_pwm_ctrl: a behavioural model tracks mode,
// carrier position, applied duty and shadow duty from the documented rules,
// and a compare process checks every DUT output against it each cycle.
// Directed scenarios pin the model with literal expectations; a randomized
// phase follows.
module tb_boost_pwm_ctrl;
  localparam int CNT_W    = 10;
  localparam int PERIOD   = 10;
  localparam int DUTY_MAX = 8;
  localparam int SS_STEP  = 2;

  logic clk = 1'b0;
  logic rst;

  boost_pwm_ctrl_if #(.CNT_W(CNT_W)) bus ();

  boost_pwm_ctrl #(
    .CNT_W(CNT_W), .PERIOD(PERIOD), .DUTY_MAX(DUTY_MAX), .SS_STEP(SS_STEP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;

  // Model: mode 0=off,1=ramping,2=regulating,3=faulted
  int m_st = 0, m_cnt = 0, m_d = 0, m_sh = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  always @(posedge clk) begin : model
    int sh_new;
    bit running;
    if (rst) begin
      m_st = 0; m_cnt = 0; m_d = 0; m_sh = 0;
    end else begin
      sh_new = bus.duty_ld ? min2(int'(bus.duty_cmd), DUTY_MAX) : m_sh;
      running = (m_st == 1) || (m_st == 2);
      if (bus.fault_in) begin
        m_st = 3; m_cnt = 0; m_d = 0;
      end else if (m_st == 0) begin
        if (bus.en) m_st = 1;
        m_cnt = 0; m_d = 0;
      end else if (m_st == 3) begin
        if (bus.fault_clr) m_st = 0;
      end else if (running && !bus.en) begin
        m_st = 0; m_cnt = 0; m_d = 0;
      end else begin
        m_cnt = (m_cnt + 1) % PERIOD;
        if (m_cnt == 0) begin
          m_d = (m_st == 2) ? m_sh : min2(m_d + SS_STEP, m_sh);
          if (m_d == m_sh) m_st = 2;
        end
      end
      m_sh = sh_new;
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    bit act;
    if (started) begin
      act = (m_st == 1) || (m_st == 2);
      chk("sp",           int'(bus.sp),           int'(act && (m_cnt < m_d)));
      chk("cnt",          int'(bus.cnt),          m_cnt);
      chk("period_start", int'(bus.period_start), int'(act && (m_cnt == 0)));
      chk("duty_act",     int'(bus.duty_act),     m_d);
      chk("state",        int'(bus.state),        m_st);
      chk("fault",        int'(bus.fault),        int'(m_st == 3));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_cnt(input int v);
    int n = 0;
    while (!(m_cnt == v && (m_st == 1 || m_st == 2)) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_cnt: carrier never reached %0d (got %0d)", v, m_cnt);
    end
  endtask

  task automatic meas(output int hi, output int ps, output int d0, output int s0);
    d0 = int'(bus.duty_act);
    s0 = int'(bus.state);
    hi = 0; ps = 0;
    repeat (PERIOD) begin
      hi += int'(bus.sp);
      ps += int'(bus.period_start);
      tick();
    end
  endtask

  initial begin
    int hi, ps, d0, s0, n;
    rst = 1'b1;
    bus.en = 1'b0; bus.duty_cmd = '0; bus.duty_ld = 1'b0;
    bus.fault_in = 1'b0; bus.fault_clr = 1'b0;
    repeat (3) tick();
    chk("rst_sp", int'(bus.sp), 0);
    chk("rst_state", int'(bus.state), 0);
    chk("rst_duty", int'(bus.duty_act), 0);
    chk("rst_fault", int'(bus.fault), 0);
    rst = 1'b0;
    repeat (5) tick();
    chk("idle_cnt", int'(bus.cnt), 0);

    // soft-start to 6
    bus.duty_cmd = 10'd6; bus.duty_ld = 1'b1; tick(); bus.duty_ld = 1'b0;
    bus.en = 1'b1; tick();
    chk("ss_state", int'(bus.state), 1);
    chk("ss_cnt0", int'(bus.cnt), 0);
    chk("ss_ps", int'(bus.period_start), 1);
    for (int k = 0; k < 4; k++) begin
      meas(hi, ps, d0, s0);
      chk("ramp_duty", d0, 2 * k);
      chk("ramp_sp_cycles", hi, 2 * k);
      chk("ramp_ps_pulses", ps, 1);
      chk("ramp_state", s0, (k == 3) ? 2 : 1);
    end

    // clamp and wrap-cycle load
    bus.duty_cmd = 10'd9; bus.duty_ld = 1'b1; tick(); bus.duty_ld = 1'b0;
    wait_cnt(0);
    chk("clamp_duty", int'(bus.duty_act), 8);
    wait_cnt(9);
    bus.duty_cmd = 10'd3; bus.duty_ld = 1'b1; tick(); bus.duty_ld = 1'b0;
    chk("wrapload_old", int'(bus.duty_act), 8);
    tick(); wait_cnt(0);
    chk("wrapload_new", int'(bus.duty_act), 3);

    // fault latch and clear
    wait_cnt(2);
    chk("pre_fault_sp", int'(bus.sp), 1);
    bus.fault_in = 1'b1; tick(); bus.fault_in = 1'b0;
    chk("fault_sp", int'(bus.sp), 0);
    chk("fault_state", int'(bus.state), 3);
    chk("fault_flag", int'(bus.fault), 1);
    bus.fault_in = 1'b1; bus.fault_clr = 1'b1; tick();
    chk("clr_ignored", int'(bus.state), 3);
    bus.fault_in = 1'b0; tick(); bus.fault_clr = 1'b0;
    chk("clr_idle", int'(bus.state), 0);
    tick();
    chk("restart_state", int'(bus.state), 1);
    chk("restart_duty", int'(bus.duty_act), 0);

    // disable mid-period
    wait_cnt(4);
    bus.en = 1'b0; tick();
    chk("dis_state", int'(bus.state), 0);
    chk("dis_sp", int'(bus.sp), 0);
    chk("dis_cnt", int'(bus.cnt), 0);
    bus.en = 1'b1; tick();
    chk("reen_duty", int'(bus.duty_act), 0);
    tick(); wait_cnt(0);
    chk("reen_ramp", int'(bus.duty_act), 2);

    // fault beats disable; reset mid-run
    bus.en = 1'b0; bus.fault_in = 1'b1; tick();
    chk("simul_fault", int'(bus.state), 3);
    bus.en = 1'b1; bus.fault_in = 1'b0; bus.fault_clr = 1'b1; tick();
    bus.fault_clr = 1'b0;
    n = 0;
    while (m_st != 2 && n < 80) begin tick(); n++; end
    if (n >= 80) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_run: never reached run (state %0d)", m_st);
    end
    wait_cnt(5);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rrst_sp", int'(bus.sp), 0);
    chk("rrst_cnt", int'(bus.cnt), 0);
    chk("rrst_state", int'(bus.state), 0);
    chk("rrst_duty", int'(bus.duty_act), 0);
    chk("rrst_ps", int'(bus.period_start), 0);

    // randomized traffic
    repeat (3000) begin
      rst           = ($urandom % 700) == 0;
      bus.en        = ($urandom % 60) != 0;
      bus.duty_ld   = ($urandom % 8) == 0;
      bus.duty_cmd  = 10'($urandom_range(0, 15));
      bus.fault_in  = ($urandom % 150) == 0;
      bus.fault_clr = ($urandom % 15) == 0;
      tick();
    end
    rst = 1'b0; bus.duty_ld = 1'b0; bus.fault_in = 1'b0; bus.fault_clr = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
